icache_direct: RTL
==================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-block instruction cache between the processor datapath and the instruction port of the memory controller.
- Serves instruction fetches combinationally on a hit.
- On a miss, runs a single-word fill over the iREN/iaddr/iload/iwait handshake; the memory controller arbitrates that port at lower priority than data.
- One instance per core.

Parameters:
- SETS, 16, number of frames; power of two, at least 2; IDX_W = log2(SETS).
- WORD_W, 32, instruction/data word width; address is also 32 bits.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  fetch satisfied this cycle.
- imemload  out  WORD_W  instruction word; valid when ihit=1.
- iREN  out  1  read request to memory controller.
- iaddr  out  32  read address to memory controller, word aligned.
- iload  in  WORD_W  read data from memory controller.
- iwait  in  1  1 = memory busy; 0 = iload valid this cycle.

Behaviour:
- Address split: index = imemaddr[IDX_W+1:2]; tag = imemaddr[31:IDX_W+2]; bits [1:0] = byte offset.
- Storage: SETS frames of {valid, tag, data}.
- Reset (nRST=0, asynchronous):
  - all valid bits = 0; state = IDLE; miss-address register = 0.
  - outputs: ihit=0, iREN=0, iaddr=0, imemload=0.
  - tag and data arrays need not be cleared.
- State IDLE:
  - ihit = imemREN & valid[index] & (tag == stored tag), combinational, zero-cycle hit.
  - imemload = data[index] whenever ihit=1; 0 otherwise.
  - imemREN=1 with no hit: latch {imemaddr[31:2], 2'b00} into the miss register; next state FETCH; ihit=0 this cycle.
  - imemREN=0: ihit=0; no state change.
- State FETCH:
  - iREN=1; iaddr = miss register; ihit=0.
  - iwait=1: stay in FETCH.
  - iwait=0: on the clock edge, write iload, the miss tag and valid=1 into the frame at the miss index; next state IDLE.
  - The next cycle re-evaluates the hit in IDLE, so miss latency is (memory wait cycles + 2) cycles.
- iREN and iaddr are 0 in IDLE.
- A fill, once started, always completes, even if imemREN drops or imemaddr changes mid-fetch (branch redirect).
  - The filled frame uses the latched address, not the current one.
  - After return to IDLE, the current imemaddr is looked up fresh.
- A fill replaces any valid frame at that index; no write-back is needed because the cache is read-only.
- Reset asserted mid-FETCH: abort immediately, iREN=0, and no frame is written.
- No self-modifying-code support; no invalidate input.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined, two extra outputs are present:
  - hit_count (32-bit): increments on every cycle with ihit=1.
  - miss_count (32-bit): increments on every IDLE->FETCH transition.
  - Both reset to 0, wrap at 2^32-1 -> 0, and are unaffected by stalls.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold miss, then hit:
  - Stimulus: after reset, imemREN=1, imemaddr=0x0000_0040; memory holds iwait=1 for 3 cycles, then iwait=0 with iload=0x2002_0004.
  - Required: iREN=1 with iaddr=0x40 for 4 cycles, then iREN=0; the following cycle ihit=1 and imemload=0x2002_0004.
- Conflict eviction:
  - Stimulus: fill 0x0000_0040 (data A), then fetch 0x0000_0080 (same index 0 for SETS=16, data B), then fetch 0x40 again.
  - Required: the fetch of 0x80 misses; the second fetch of 0x40 misses and iaddr=0x40; imemload returns A after that refill.
- Redirect mid-fetch:
  - Stimulus: miss on 0x100, then change imemaddr to 0x200 while iwait=1.
  - Required: iaddr stays 0x100 until iwait=0; frame 0 is then valid with tag of 0x100; the next IDLE cycle misses on 0x200 and issues iaddr=0x200.
- Byte offset ignored: after 0x44 is filled, imemaddr=0x47 -> ihit=1 with the same data.
- Reset mid-fetch:
  - Stimulus: pull nRST low while in FETCH for 0x40, then release.
  - Required: iREN=0 immediately; a fetch of 0x40 after release misses.
- With ICACHE_STATS_EN: the sequence miss 0x40, 3 hits on 0x40, miss 0x80 gives hit_count=3, miss_count=2.

Source files
------------

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-block instruction cache.
// Hits are served combinationally in IDLE. A miss runs a single-word fill
// over the iREN/iaddr/iload/iwait handshake.
// Optional macro ICACHE_STATS_EN adds the hit_count / miss_count outputs.
module icache_direct #(
    parameter int SETS   = 16,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [31:0]       imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [31:0]       iaddr,
    input  logic [WORD_W-1:0] iload,
    input  logic              iwait
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state;
    logic [29:0]       miss_word;   // latched word address of the pending fill
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [WORD_W-1:0] data [SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]  miss_tag;
    logic              lookup_hit;
    logic              start_miss;
    logic              fill;
    logic              unused_bits;

    assign idx        = imemaddr[IDX_W+1:2];
    assign tag        = imemaddr[31:IDX_W+2];
    assign miss_idx   = miss_word[IDX_W-1:0];
    assign miss_tag   = miss_word[29:IDX_W];
    assign unused_bits = ^imemaddr[1:0];   // byte offset never matters for fetches

    // Lookup only counts as a hit while no fill is outstanding
    assign lookup_hit = imemREN && valid[idx] && (tags[idx] == tag);
    assign ihit       = (state == IDLE) && lookup_hit;
    assign imemload   = ihit ? data[idx] : '0;
    assign iaddr      = iREN ? {miss_word, 2'b00} : 32'd0;
    assign start_miss = (state == IDLE) && imemREN && !lookup_hit;
    // iREN is low during reset, so a reset mid-fetch can never write a frame
    assign fill       = iREN && !iwait;

    // Fill FSM: IDLE -> FETCH on a miss, back to IDLE once memory returns data
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            iREN      <= 1'b0;
            miss_word <= '0;
            valid     <= '0;
        end else begin
            case (state)
                IDLE: if (start_miss) begin
                    state     <= FETCH;
                    iREN      <= 1'b1;
                    miss_word <= imemaddr[31:2];
                end
                FETCH: if (!iwait) begin
                    state           <= IDLE;
                    iREN            <= 1'b0;
                    valid[miss_idx] <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    iREN  <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays are not reset; the valid bits guard them
    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[miss_idx] <= miss_tag;
            data[miss_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    // Free-running hit/miss counters, wrapping naturally at 2^32
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit)       hit_count  <= hit_count + 32'd1;
            if (start_miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
